// File: rtl/timer_apb_pkg.sv
// +--------------------------------------------------------------------------+
// | Module : timer_apb_pkg                                                   |
// | Brief  : Register map, field positions and APB FSM states of the timer   |
// |          register slave.                                                 |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package timer_apb_pkg;

    localparam logic [2:0] C_ADDR_TDR  = 3'h0;
    localparam logic [2:0] C_ADDR_TCR  = 3'h1;
    localparam logic [2:0] C_ADDR_TSR  = 3'h2;
    localparam logic [2:0] C_ADDR_TIER = 3'h3;
    localparam logic [2:0] C_ADDR_TCNT = 3'h4;

    localparam int C_TCR_LOAD       = 7;
    localparam int C_TCR_DW         = 5;
    localparam int C_TCR_EN         = 4;
    localparam int C_TCR_CLKSEL_LSB = 0;

    // Implemented TCR bits: LOAD, DW, EN and CLKSEL[1:0]
    localparam logic [7:0] C_TCR_MASK = 8'hB3;

    localparam int C_TSR_OVF = 0;
    localparam int C_TSR_UDF = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    function automatic logic addr_mapped(input logic [2:0] addr);
        return addr <= C_ADDR_TCNT;
    endfunction

endpackage

`default_nettype wire

// File: rtl/timer_apb_fsm.sv
// +--------------------------------------------------------------------------+
// | Module : timer_apb_fsm                                                   |
// | Brief  : APB transfer sequencer with programmable wait states; issues    |
// |          pready, a single-cycle commit strobe and a read-capture strobe. |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module timer_apb_fsm
    import timer_apb_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_psel,
    input  logic i_penable,
    output logic o_pready,
    output logic o_commit,
    output logic o_rd_load
);

    localparam logic [2:0] C_WAIT_INIT = 3'(WAIT_CYCLES);

    apb_state_t r_state;
    apb_state_t w_state_nxt;
    logic [2:0] r_wait;
    logic [2:0] w_wait_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_wait  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    // o_rd_load fires one cycle ahead of pready so read data can be registered
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        o_pready    = 1'b0;
        o_rd_load   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_psel && !i_penable) begin
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (!i_psel) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = ACCESS;
                    w_wait_nxt  = C_WAIT_INIT;
                    o_rd_load   = (C_WAIT_INIT == 3'd0);
                end
            end
            ACCESS: begin
                if (!i_psel) begin
                    w_state_nxt = IDLE;
                    w_wait_nxt  = 3'd0;
                end else if (r_wait != 3'd0) begin
                    w_wait_nxt = r_wait - 3'd1;
                    o_rd_load  = (r_wait == 3'd1);
                end else begin
                    o_pready    = 1'b1;
                    w_state_nxt = i_penable ? IDLE : SETUP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_commit = o_pready;

endmodule

`default_nettype wire

// File: rtl/timer_apb_slave.sv
// +--------------------------------------------------------------------------+
// | Module : timer_apb_slave                                                 |
// | Brief  : APB register file for the 8-bit timer (TDR/TCR/TSR/TIER/TCNT).  |
// |          Optional interrupt logic enabled by macro TIMER_IRQ_EN.         |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module timer_apb_slave
    import timer_apb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [7:0]        pwdata,
    output logic [7:0]        prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [7:0]        cnt_val,
    input  logic              ovf_pulse,
    input  logic              udf_pulse,
    output logic [7:0]        tdr_o,
    output logic              load_o,
    output logic              dw_o,
    output logic              en_o,
    output logic [1:0]        clk_sel_o,
    output logic              irq
);

    logic       w_commit;
    logic       w_rd_load;
    logic       w_upper_zero;
    logic       w_mapped;
    logic       w_wr;
    logic [2:0] w_reg_addr;
    logic [7:0] w_rdata;
    logic [1:0] w_tsr_nxt;
    logic [1:0] w_tier;

    logic [7:0] r_tdr;
    logic [7:0] r_tcr;
    logic [1:0] r_tsr;
    logic [7:0] r_prdata;
    logic       r_pslverr;

    timer_apb_fsm #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_fsm (
        .clk       (pclk),
        .rst_n     (presetn),
        .i_psel    (psel),
        .i_penable (penable),
        .o_pready  (pready),
        .o_commit  (w_commit),
        .o_rd_load (w_rd_load)
    );

    generate
        if (ADDR_W > 3) begin : g_upper_decode
            assign w_upper_zero = ~|paddr[ADDR_W-1:3];
        end else begin : g_no_upper
            assign w_upper_zero = 1'b1;
        end
    endgenerate

    assign w_reg_addr = paddr[2:0];
    assign w_mapped   = w_upper_zero && addr_mapped(w_reg_addr);
    assign w_wr       = w_commit && pwrite && w_mapped;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_tdr <= 8'h00;
            r_tcr <= 8'h00;
            r_tsr <= 2'b00;
        end else begin
            if (w_wr && (w_reg_addr == C_ADDR_TDR)) begin
                r_tdr <= pwdata;
            end
            if (w_wr && (w_reg_addr == C_ADDR_TCR)) begin
                r_tcr <= pwdata & C_TCR_MASK;
            end
            r_tsr <= w_tsr_nxt;
        end
    end

    // Write-0-to-clear first, then OR in the core's events so a set wins
    always_comb begin
        w_tsr_nxt = r_tsr;
        if (w_wr && (w_reg_addr == C_ADDR_TSR)) begin
            w_tsr_nxt = r_tsr & pwdata[1:0];
        end
        w_tsr_nxt[C_TSR_OVF] = w_tsr_nxt[C_TSR_OVF] | ovf_pulse;
        w_tsr_nxt[C_TSR_UDF] = w_tsr_nxt[C_TSR_UDF] | udf_pulse;
    end

`ifdef TIMER_IRQ_EN
    logic [1:0] r_tier;
    logic       r_irq;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_tier <= 2'b00;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr && (w_reg_addr == C_ADDR_TIER)) begin
                r_tier <= pwdata[1:0];
            end
            r_irq <= |(r_tsr & r_tier);
        end
    end

    assign w_tier = r_tier;
    assign irq    = r_irq;
`else
    assign w_tier = 2'b00;
    assign irq    = 1'b0;
`endif

    always_comb begin
        w_rdata = 8'h00;
        case (w_reg_addr)
            C_ADDR_TDR:  w_rdata = r_tdr;
            C_ADDR_TCR:  w_rdata = r_tcr;
            C_ADDR_TSR:  w_rdata = {6'b0, r_tsr};
            C_ADDR_TIER: w_rdata = {6'b0, w_tier};
            C_ADDR_TCNT: w_rdata = cnt_val;
            default:     w_rdata = 8'h00;
        endcase
    end

    // Read data and error are captured the cycle before pready
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_prdata  <= 8'h00;
            r_pslverr <= 1'b0;
        end else begin
            r_prdata  <= (w_rd_load && !pwrite && w_mapped) ? w_rdata : 8'h00;
            r_pslverr <= w_rd_load && !w_mapped;
        end
    end

    assign prdata  = pready ? r_prdata : 8'h00;
    assign pslverr = pready && r_pslverr;

    assign tdr_o     = r_tdr;
    assign load_o    = r_tcr[C_TCR_LOAD];
    assign dw_o      = r_tcr[C_TCR_DW];
    assign en_o      = r_tcr[C_TCR_EN];
    assign clk_sel_o = r_tcr[C_TCR_CLKSEL_LSB +: 2];

endmodule

`default_nettype wire
